// File: rtl/ppu_vram_ctrl.sv
// ============================================================================
// ppu_vram_ctrl : PPU VRAM address registers (v/t/fine x/w) and bus sequencer
// Optional: PPU_PAL_READ_BYPASS_EN (palette reads bypass the $2007 buffer)
// Revision: 1.0
// ============================================================================
`default_nettype none

module ppu_vram_ctrl #(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  reg_sel,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [7:0]  reg_din,
  output logic [7:0]  rd_data,
  input  logic        inc32,
  input  logic        rend,
  input  logic        inc_cx,
  input  logic        inc_y,
  input  logic        return00,
  input  logic        fetch_attr,
  input  logic        fetch_chr,
  input  logic [12:0] pattern_idx,
  output logic [2:0]  fine_x,
  output logic [1:0]  attr_o,
  output logic [13:0] vram_addr,
  output logic        vram_rd,
  output logic        vram_wr,
  output logic [7:0]  vram_dout,
  input  logic [7:0]  vram_din,
  input  logic [7:0]  pal_rdata,
  output logic        busy
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_ACC      = 2'd1;
  localparam logic [1:0] c_DONE     = 2'd2;
  localparam logic [1:0] c_LAT_LAST = 2'(RD_LATENCY - 1);

  logic [14:0] r_v, r_t;
  logic        r_w;
  logic [2:0]  r_fine_x;
  logic [7:0]  r_buf;
  logic [1:0]  r_state;
  logic        r_op_wr, r_pal, r_incy_d;
  logic [7:0]  r_wdata;
  logic [1:0]  r_lat;

  logic        w_acc2007, w_start, w_glitch, w_copy6, w_pal_hit;
  logic        w_do_cx, w_do_y, w_hcopy, w_vcopy;
  logic [14:0] w_t_nxt, w_v_inc, w_v_nxt;
  logic        w_w_nxt;
  logic [2:0]  w_fx_nxt;

  assign busy      = (r_state != c_IDLE);
  assign w_acc2007 = (reg_wr || reg_rd) && (reg_sel == 3'd7);
  assign w_start   = w_acc2007 && !busy && !rend;
  assign w_glitch  = w_acc2007 && !busy && rend;
  assign w_copy6   = reg_wr && (reg_sel == 3'd6) && r_w;
  assign fine_x    = r_fine_x;
  assign vram_dout = r_wdata;

`ifdef PPU_PAL_READ_BYPASS_EN
  assign w_pal_hit = w_start && reg_rd && !reg_wr && (r_v[13:8] == 6'h3F);
  assign rd_data   = w_pal_hit ? pal_rdata : r_buf;
`else
  logic w_unused_pal;
  assign w_unused_pal = ^pal_rdata;
  assign w_pal_hit    = 1'b0;
  assign rd_data      = r_buf;
`endif

  // CPU register writes into t / fine x / write toggle
  always_comb begin
    w_t_nxt  = r_t;
    w_w_nxt  = r_w;
    w_fx_nxt = r_fine_x;
    if (reg_wr) begin
      case (reg_sel)
        3'd0: w_t_nxt[11:10] = reg_din[1:0];
        3'd5: begin
          if (!r_w) begin
            w_t_nxt[4:0] = reg_din[7:3];
            w_fx_nxt     = reg_din[2:0];
            w_w_nxt      = 1'b1;
          end else begin
            w_t_nxt[14:12] = reg_din[2:0];
            w_t_nxt[9:5]   = reg_din[7:3];
            w_w_nxt        = 1'b0;
          end
        end
        3'd6: begin
          if (!r_w) begin
            w_t_nxt[13:8] = reg_din[5:0];
            w_t_nxt[14]   = 1'b0;
            w_w_nxt       = 1'b1;
          end else begin
            w_t_nxt[7:0] = reg_din;
            w_w_nxt      = 1'b0;
          end
        end
        default: ;
      endcase
    end
    if (reg_rd && (reg_sel == 3'd2)) w_w_nxt = 1'b0;
  end

  // v next-state: only the highest-priority source applies, except cx+y together
  always_comb begin
    w_do_cx = rend && (inc_cx || w_glitch);
    w_do_y  = rend && (inc_y || w_glitch);
    w_hcopy = rend && r_incy_d;
    w_vcopy = rend && return00;
    w_v_inc = r_v;
    if (w_do_cx) begin
      if (r_v[4:0] == 5'd31) begin
        w_v_inc[4:0] = 5'd0;
        w_v_inc[10]  = ~r_v[10];
      end else begin
        w_v_inc[4:0] = r_v[4:0] + 5'd1;
      end
    end
    if (w_do_y) begin
      if (r_v[14:12] != 3'd7) begin
        w_v_inc[14:12] = r_v[14:12] + 3'd1;
      end else begin
        w_v_inc[14:12] = 3'd0;
        if (r_v[9:5] == 5'd29) begin
          w_v_inc[9:5] = 5'd0;
          w_v_inc[11]  = ~r_v[11];
        end else if (r_v[9:5] == 5'd31) begin
          w_v_inc[9:5] = 5'd0;
        end else begin
          w_v_inc[9:5] = r_v[9:5] + 5'd1;
        end
      end
    end
    w_v_nxt = w_v_inc;
    if (w_copy6) begin
      w_v_nxt = w_t_nxt;
    end else if (r_state == c_DONE) begin
      w_v_nxt = r_v + (inc32 ? 15'd32 : 15'd1);
    end else if (w_hcopy || w_vcopy) begin
      w_v_nxt = r_v;
      if (w_hcopy) begin
        w_v_nxt[10]  = r_t[10];
        w_v_nxt[4:0] = r_t[4:0];
      end
      if (w_vcopy) begin
        w_v_nxt[14:11] = r_t[14:11];
        w_v_nxt[9:5]   = r_t[9:5];
      end
    end
  end

  // Bus mux: a CPU access in flight owns the bus even if rendering has started
  always_comb begin
    vram_addr = r_v[13:0];
    vram_rd   = 1'b0;
    vram_wr   = 1'b0;
    if (r_state == c_ACC) begin
      vram_addr = r_pal ? (r_v[13:0] - 14'h1000) : r_v[13:0];
      vram_wr   = r_op_wr;
      vram_rd   = !r_op_wr;
    end else if ((r_state == c_IDLE) && rend) begin
      vram_rd = 1'b1;
      if (fetch_chr)
        vram_addr = {1'b0, pattern_idx};
      else if (fetch_attr)
        vram_addr = {2'b10, r_v[11:10], 4'b1111, r_v[9:7], r_v[4:2]};
      else
        vram_addr = {2'b10, r_v[11:0]};
    end
  end

  always_comb begin
    case ({r_v[6], r_v[1]})
      2'd0:    attr_o = vram_din[1:0];
      2'd1:    attr_o = vram_din[3:2];
      2'd2:    attr_o = vram_din[5:4];
      default: attr_o = vram_din[7:6];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v      <= 15'd0;
      r_t      <= 15'd0;
      r_w      <= 1'b0;
      r_fine_x <= 3'd0;
      r_buf    <= 8'd0;
      r_state  <= c_IDLE;
      r_op_wr  <= 1'b0;
      r_pal    <= 1'b0;
      r_wdata  <= 8'd0;
      r_lat    <= 2'd0;
      r_incy_d <= 1'b0;
    end else begin
      r_v      <= w_v_nxt;
      r_t      <= w_t_nxt;
      r_w      <= w_w_nxt;
      r_fine_x <= w_fx_nxt;
      r_incy_d <= rend && inc_y;
      case (r_state)
        c_IDLE: begin
          if (w_start) begin
            r_state <= c_ACC;
            r_op_wr <= reg_wr;
            r_wdata <= reg_din;
            r_pal   <= w_pal_hit;
            r_lat   <= 2'd0;
          end
        end
        c_ACC: begin
          if (r_op_wr || (r_lat == c_LAT_LAST)) r_state <= c_DONE;
          else                                  r_lat   <= r_lat + 2'd1;
        end
        c_DONE: begin
          if (!r_op_wr) r_buf <= vram_din;
          r_pal   <= 1'b0;
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ppu_vram_ctrl.sv
// Directed bench for ppu_vram_ctrl with a simple latency-1 VRAM model.
`default_nettype none

module tb_ppu_vram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  reg_sel;
  logic        reg_wr, reg_rd;
  logic [7:0]  reg_din;
  logic [7:0]  rd_data;
  logic        inc32, rend, inc_cx, inc_y, return00, fetch_attr, fetch_chr;
  logic [12:0] pattern_idx;
  logic [2:0]  fine_x;
  logic [1:0]  attr_o;
  logic [13:0] vram_addr;
  logic        vram_rd, vram_wr;
  logic [7:0]  vram_dout;
  logic [7:0]  vram_din;
  logic [7:0]  pal_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int snap, nbusy;

  logic [7:0]  mem [0:16383];
  logic        tb_we = 1'b0;
  logic [13:0] tb_a  = 14'd0;
  logic [7:0]  tb_d  = 8'd0;

  always #5 clk = ~clk;

  ppu_vram_ctrl #(.RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .reg_sel(reg_sel), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_din(reg_din), .rd_data(rd_data), .inc32(inc32), .rend(rend),
    .inc_cx(inc_cx), .inc_y(inc_y), .return00(return00), .fetch_attr(fetch_attr),
    .fetch_chr(fetch_chr), .pattern_idx(pattern_idx), .fine_x(fine_x),
    .attr_o(attr_o), .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_wr(vram_wr),
    .vram_dout(vram_dout), .vram_din(vram_din), .pal_rdata(pal_rdata), .busy(busy)
  );

  initial vram_din = 8'd0;

  always @(posedge clk) begin
    if (tb_we)        mem[tb_a] <= tb_d;
    else if (vram_wr) mem[vram_addr] <= vram_dout;
    if (vram_rd)      vram_din <= mem[vram_addr];
    if (vram_wr)      wr_cnt <= wr_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [2:0] sel, input logic [7:0] d);
    reg_sel = sel; reg_din = d; reg_wr = 1'b1;
    @(negedge clk);
    reg_wr = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] sel);
    reg_sel = sel; reg_rd = 1'b1;
    @(negedge clk);
    reg_rd = 1'b0;
  endtask

  task automatic rd2007(input string tag, input logic [7:0] exp);
    reg_sel = 3'd7; reg_rd = 1'b1;
    #1 check(tag, 16'(rd_data), 16'(exp));
    @(negedge clk);
    reg_rd = 1'b0;
  endtask

  task automatic preload(input logic [13:0] a, input logic [7:0] d);
    tb_a = a; tb_d = d; tb_we = 1'b1;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'd0;
    rst = 1'b1; reg_sel = 3'd0; reg_wr = 1'b0; reg_rd = 1'b0; reg_din = 8'd0;
    inc32 = 1'b0; rend = 1'b0; inc_cx = 1'b0; inc_y = 1'b0; return00 = 1'b0;
    fetch_attr = 1'b0; fetch_chr = 1'b0; pattern_idx = 13'd0; pal_rdata = 8'd0;
    repeat (3) @(negedge clk);

    check("rst_addr", 16'(vram_addr), 16'h0000);
    check("rst_rdwr", {14'd0, vram_rd, vram_wr}, 16'h0000);
    check("rst_busy", 16'(busy), 16'h0000);
    check("rst_rd_data", 16'(rd_data), 16'h0000);
    check("rst_fine_x", 16'(fine_x), 16'h0000);
    rst = 1'b0;

    preload(14'h2000, 8'h11);
    preload(14'h2001, 8'h22);
    preload(14'h2BC1, 8'h1E);
    preload(14'h2F01, 8'h99);

    // $2005 pair, then the same with a $2002 read in between
    reg_write(3'd5, 8'h7D);
    reg_write(3'd5, 8'h5E);
    check("p2005_t", 16'(dut.r_t), 16'h616F);
    check("p2005_fx", 16'(fine_x), 16'h0005);
    reg_write(3'd5, 8'h7D);
    reg_read(3'd2);
    reg_write(3'd5, 8'h5E);
    check("p2002_t", 16'(dut.r_t), 16'h616B);
    check("p2002_fx", 16'(fine_x), 16'h0006);
    reg_read(3'd2);
    check("p2002_w", 16'(dut.r_w), 16'h0000);
    reg_write(3'd0, 8'h02);
    check("p2000_t", 16'(dut.r_t), 16'h696B);

    // $2006 load and a single $2007 write
    reg_write(3'd6, 8'h21);
    reg_write(3'd6, 8'h08);
    check("p2006_v", 16'(vram_addr), 16'h2108);
    check("p2006_w", 16'(dut.r_w), 16'h0000);
    snap = wr_cnt; nbusy = 0;
    reg_write(3'd7, 8'h5A);
    check("wr_addr", 16'(vram_addr), 16'h2108);
    check("wr_dout", {vram_wr, 7'd0, vram_dout}, 16'h805A);
    for (int i = 0; i < 4; i++) begin
      if (busy) nbusy++;
      @(negedge clk);
    end
    check("wr_count", 16'(wr_cnt - snap), 16'd1);
    check("wr_busy_cycles", 16'(nbusy), 16'd2);
    check("wr_v_step", 16'(vram_addr), 16'h2109);
    check("wr_mem", 16'(mem[14'h2108]), 16'h005A);

    // back-to-back $2007 writes: second is dropped
    reg_write(3'd6, 8'h23);
    reg_write(3'd6, 8'h00);
    snap = wr_cnt;
    reg_write(3'd7, 8'h77);
    reg_write(3'd7, 8'h88);
    repeat (4) @(negedge clk);
    check("drop_count", 16'(wr_cnt - snap), 16'd1);
    check("drop_v", 16'(vram_addr), 16'h2301);
    check("drop_mem", {mem[14'h2300], mem[14'h2301]}, 16'h7700);

    // buffered reads
    reg_write(3'd6, 8'h20);
    reg_write(3'd6, 8'h00);
    rd2007("rd1_stale", 8'h00);
    repeat (3) @(negedge clk);
    rd2007("rd2_buf", 8'h11);
    repeat (3) @(negedge clk);
    check("rd_buf_after", 16'(rd_data), 16'h0022);
    check("rd_v", 16'(vram_addr), 16'h2002);

    // $2007 write while rendering: no bus cycle, coarse X and Y step
    reg_write(3'd6, 8'h00);
    reg_write(3'd6, 8'h00);
    snap = wr_cnt;
    rend = 1'b1; reg_sel = 3'd7; reg_din = 8'h33; reg_wr = 1'b1;
    @(negedge clk);
    reg_wr = 1'b0;
    check("glitch_v", 16'(dut.r_v), 16'h1001);
    check("glitch_addr", 16'(vram_addr), 16'h2001);
    check("glitch_busy", 16'(busy), 16'h0000);
    @(negedge clk);
    check("glitch_nowr", 16'(wr_cnt - snap), 16'd0);
    rend = 1'b0;

    // coarse X wrap
    reg_write(3'd6, 8'h00);
    reg_write(3'd6, 8'h1F);
    rend = 1'b1; inc_cx = 1'b1;
    @(negedge clk);
    inc_cx = 1'b0;
    check("cx_wrap", {1'b0, vram_rd, vram_addr}, 16'h6400);
    rend = 1'b0;

    // return00, Y wrap at 29, delayed horizontal copy
    reg_write(3'd6, 8'h00);
    reg_write(3'd6, 8'h00);
    reg_write(3'd5, 8'h28);
    reg_write(3'd5, 8'hEF);
    rend = 1'b1; return00 = 1'b1;
    @(negedge clk);
    return00 = 1'b0;
    check("ret00", 16'(dut.r_v), 16'h73A0);
    inc_y = 1'b1;
    @(negedge clk);
    inc_y = 1'b0;
    check("y_wrap", 16'(vram_addr), 16'h2800);
    @(negedge clk);
    check("hcopy", 16'(vram_addr), 16'h2805);
    fetch_attr = 1'b1;
    #1 check("attr_addr", 16'(vram_addr), 16'h2BC1);
    @(negedge clk);
    fetch_attr = 1'b0;
    check("attr_o", 16'(attr_o), 16'h0002);
    fetch_chr = 1'b1; pattern_idx = 13'h1ABC;
    #1 check("chr_addr", 16'(vram_addr), 16'h1ABC);
    @(negedge clk);
    fetch_chr = 1'b0; rend = 1'b0;

`ifdef PPU_PAL_READ_BYPASS_EN
    reg_write(3'd6, 8'h3F);
    reg_write(3'd6, 8'h01);
    pal_rdata = 8'h2C;
    rd2007("pal_bypass", 8'h2C);
    repeat (3) @(negedge clk);
    check("pal_buf", 16'(rd_data), 16'h0099);
    check("pal_v", 16'(vram_addr), 16'h3F02);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ppu_vram_ctrl.md
Name: ppu_vram_ctrl

Overview:
- Owns the PPU VRAM address registers: v (15b), t (15b), fine x (3b) and write toggle w.
- Sequences every PPU bus cycle. During rendering it forms nametable/attribute/pattern addresses for the render block; outside rendering it runs CPU $2007 accesses.
- Applies the render block's scroll pulses (inc_cx, inc_y, return00) to v.
- Sits between the CPU register decode, the render block and the VRAM/CHR bus.

Parameters:
- RD_LATENCY, 1, cycles from vram_rd to vram_din valid; legal values are 1 or 2.

Ports:
- clk  in  1  PPU clock
- rst  in  1  synchronous, active-high reset
- reg_sel  in  3  CPU register index ($2000+reg_sel)
- reg_wr  in  1  one-cycle CPU write strobe
- reg_rd  in  1  one-cycle CPU read strobe
- reg_din  in  8  CPU write data
- rd_data  out  8  $2007 read buffer contents
- inc32  in  1  PPUCTRL[2]; $2007 address step is 32 when set, 1 when clear
- rend  in  1  rendering active (render block rend AND PPUMASK show bg|sp)
- inc_cx  in  1  coarse-X increment pulse
- inc_y  in  1  Y increment pulse
- return00  in  1  copy vertical bits t->v
- fetch_attr  in  1  render attribute fetch cycle
- fetch_chr  in  1  render pattern fetch cycle
- pattern_idx  in  13  render pattern address
- fine_x  out  3  fine X scroll to render block
- attr_o  out  2  selected attribute quadrant
- vram_addr  out  14  PPU bus address
- vram_rd  out  1  bus read enable
- vram_wr  out  1  bus write enable
- vram_dout  out  8  bus write data
- vram_din  in  8  bus read data
- pal_rdata  in  8  palette RAM read data; used only with the optional feature
- busy  out  1  CPU $2007 access in progress

Behaviour:
- Reset: v=t=0, fine_x=0, w=0, rd_data=0, busy=0, vram_rd=vram_wr=0, vram_addr=0, FSM=IDLE.
- Register writes (t bit numbering: [14:12] fine y, [11:10] nametable, [9:5] coarse y, [4:0] coarse x):
  - $2000: t[11:10]=d[1:0].
  - $2005 with w=0: t[4:0]=d[7:3], fine_x=d[2:0], w=1.
  - $2005 with w=1: t[14:12]=d[2:0], t[9:5]=d[7:3], w=0.
  - $2006 with w=0: t[13:8]=d[5:0], t[14]=0, w=1.
  - $2006 with w=1: t[7:0]=d, w=0, and v=t(new) on the next edge.
  - Read of $2002: w=0.
- Render increments, applied only while rend=1:
  - inc_cx: coarse X+1. At 31, wrap to 0 and toggle v[10].
  - inc_y: fine Y<7 increments. Otherwise fine Y=0 and coarse Y updates: 29->0 toggling v[11]; 31->0 without toggle; else +1.
  - Horizontal copy v[10],v[4:0]=t: one cycle after each inc_y pulse (internally delayed).
  - return00: v[14:11],v[9:5]=t, every cycle it is high.
- Priority on v, highest first: $2006 second-write copy > $2007 completion step > return00/horizontal copy > inc_y > inc_cx. inc_cx and inc_y in the same cycle apply both.
- Bus mux while rend=1, combinational, vram_rd=1:
  - fetch_chr: vram_addr={0,pattern_idx}.
  - fetch_attr: vram_addr={10,v[11:10],1111,v[9:7],v[4:2]}.
  - Otherwise: vram_addr={10,v[11:0]}.
- attr_o = vram_din[2*{v[6],v[1]}+1 -: 2], combinational.
- CPU $2007 FSM:
  - IDLE: on a $2007 access with rend=0, latch the operation and go to ACC.
  - ACC: vram_addr=v[13:0]. Writes drive vram_wr=1 with vram_dout=latched data. Reads drive vram_rd=1 for RD_LATENCY cycles. Then go to DONE.
  - DONE: a read loads rd_data=vram_din. v += inc32?32:1, mod 2^15. Return to IDLE.
  - busy=1 in ACC and DONE. A $2007 access arriving while busy=1 is dropped (no side effects).
  - rd_data is the previous buffer value at strobe time (one-read-behind behaviour).
- $2007 access with rend=1: no bus cycle, rd_data unchanged, and coarse X and Y increment together (hardware glitch emulation).
- rend rising while the FSM is in ACC: the CPU access completes first and render addressing is suppressed until IDLE. The render block tolerates this because the start of rendering begins on a non-fetch cycle.
- Reset mid-access aborts the access. No write completes after the reset edge.

Optional Feature:
- Macro PPU_PAL_READ_BYPASS_EN.
- Defined: $2007 reads with v[13:8]=3F return pal_rdata on rd_data in the same cycle as the strobe. The buffer then loads VRAM data from address v-0x1000.
- Undefined: palette reads use the normal buffered path, and pal_rdata is ignored.

Test Plan:
- $2006 write 0x21 then 0x08 -> v=0x2108, w=0. Then $2007 write 0x5A with inc32=0 -> one vram_wr at 0x2108 with vram_dout=0x5A, v=0x2109, busy high for 2 cycles.
- $2005 write 0x7D then 0x5E -> fine_x=5, t[4:0]=15, t[14:12]=6, t[9:5]=11. A $2002 read between the two writes -> both writes act as first writes.
- rend=1, v=0x001F, inc_cx -> v=0x0400. v=0x73A0 (fine y 7, coarse y 29), inc_y -> v=0x0800, then horizontal copy one cycle later.
- Two $2007 reads at 0x2000 with memory 0x11,0x22 -> first rd_data is the stale buffer value 0x00, second returns 0x11, and v ends at 0x2002.
- A $2007 access one cycle after a previous one -> dropped, v advanced only once. A $2007 write with rend=1 -> no vram_wr, both coarse X and Y incremented.
- With the macro defined: v=0x3F01, pal_rdata=0x2C, $2007 read -> rd_data=0x2C in the strobe cycle, and the buffer then holds VRAM[0x2F01].
